// File: rtl/des_round_sequencer.sv
// Control sequencer for the DES core: steps IP, sixteen Feistel rounds and FP,
// issuing per-round key rotation, with a per-stage watchdog and abort path.
module des_round_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       decrypt,
  input  logic       abort,
  output logic       start_ready,
  output logic       ip_select,
  input  logic       ip_finish,
  output logic       round_go,
  output logic [4:0] round_num,
  output logic [1:0] key_shift_amt,
  output logic       key_shift_right,
  input  logic       round_done,
  output logic       fp_select,
  input  logic       fp_finish,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IP    = 3'd1,
    S_RGO   = 3'd2,
    S_RWAIT = 3'd3,
    S_FP    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [4:0]       round_q, round_nxt;
  logic             mode_q, mode_nxt;
  logic [CNT_W-1:0] wd_q;
  logic             waiting, flag, timeout;

  // Encrypt rotation: single-bit shifts in rounds 1, 2, 9 and 16, two otherwise.
  function automatic logic [1:0] enc_shift(input logic [4:0] r);
    return (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  // Decrypt walks the encrypt schedule backwards, one round late, starting unrotated.
  function automatic logic [1:0] key_shift(input logic [4:0] r, input logic dec);
    if (r == 5'd0) return 2'd0;
    if (!dec) return enc_shift(r);
    if (r == 5'd1) return 2'd0;
    return enc_shift(5'd18 - r);
  endfunction

  always_comb begin
    waiting = 1'b0;
    flag    = 1'b0;
    case (state)
      S_IP:    begin waiting = 1'b1; flag = ip_finish;  end
      S_RWAIT: begin waiting = 1'b1; flag = round_done; end
      S_FP:    begin waiting = 1'b1; flag = fp_finish;  end
      default: ;
    endcase
    timeout = waiting && !flag && (wd_q == WD_LAST);
  end

  always_comb begin
    state_nxt = state;
    round_nxt = round_q;
    mode_nxt  = mode_q;
    round_go  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          mode_nxt  = decrypt;
          round_nxt = 5'd0;
          state_nxt = S_IP;
        end
      end
      S_IP: begin
        if (ip_finish) begin
          round_nxt = 5'd1;
          state_nxt = S_RGO;
        end
      end
      S_RGO: begin
        round_go  = 1'b1;
        state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        if (round_done) begin
          if (round_q == 5'd16) begin
            state_nxt = S_FP;
          end else begin
            round_nxt = round_q + 5'd1;
            state_nxt = S_RGO;
          end
        end
      end
      S_FP: begin
        if (fp_finish) begin
          done      = 1'b1;
          round_nxt = 5'd0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort outranks timeout, which outranks any stage completion.
    if (state != S_IDLE && abort) begin
      done      = 1'b0;
      round_nxt = 5'd0;
      state_nxt = S_IDLE;
    end else if (timeout) begin
      error     = 1'b1;
      round_nxt = 5'd0;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      round_q <= 5'd0;
      mode_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
      mode_q  <= mode_nxt;
      if (state_nxt != state)
        wd_q <= '0;
      else if (waiting && !flag)
        wd_q <= wd_q + 1'b1;
    end
  end

  // Round 1 still needs the IP output, so its select stays up through the first round.
  assign ip_select       = (state == S_IP) ||
                           ((state == S_RGO || state == S_RWAIT) && round_q == 5'd1);
  assign fp_select       = (state == S_FP);
  assign start_ready     = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign round_num       = round_q;
  assign key_shift_amt   = key_shift(round_q, mode_q);
  assign key_shift_right = mode_q && (round_q != 5'd0);

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: latency-programmable stage responders and a
// schedule/latency reference derived from stage delays and the key rotation table.
module tb_des_round_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, decrypt, abort;
  logic       start_ready, ip_select, ip_finish, round_go;
  logic [4:0] round_num;
  logic [1:0] key_shift_amt;
  logic       key_shift_right, round_done, fp_select, fp_finish;
  logic       busy, done, error;

  int vec = 0;
  int miscompares = 0;

  int d_ip = 1, d_r = 1, d_fp = 1, hang_round = 0;
  int ip_cnt, r_cnt, fp_cnt;

  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_round_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .abort(abort),
    .start_ready(start_ready), .ip_select(ip_select), .ip_finish(ip_finish),
    .round_go(round_go), .round_num(round_num), .key_shift_amt(key_shift_amt),
    .key_shift_right(key_shift_right), .round_done(round_done),
    .fp_select(fp_select), .fp_finish(fp_finish), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Stage responders: answer after a programmable number of cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_cnt <= 0;
      r_cnt  <= 0;
      fp_cnt <= 0;
    end else begin
      ip_cnt <= ip_select ? ip_cnt + 1 : 0;
      fp_cnt <= fp_select ? fp_cnt + 1 : 0;
      r_cnt  <= round_go ? 1 : ((r_cnt != 0) ? r_cnt + 1 : 0);
    end
  end

  assign ip_finish  = ip_select && (ip_cnt == d_ip);
  assign fp_finish  = fp_select && (fp_cnt == d_fp);
  assign round_done = (r_cnt == d_r) && (int'(round_num) != hang_round);

  function automatic int ref_amt(input bit dec, input int r);
    if (!dec) return shifts[r-1];
    if (r == 1) return 0;
    return shifts[17-r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (start_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", start_ready, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, start_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_round"}, round_num, 0);
    chk({tag, "_ipsel"}, ip_select, 0);
    chk({tag, "_fpsel"}, fp_select, 0);
    chk({tag, "_amt"}, key_shift_amt, 0);
    chk({tag, "_right"}, key_shift_right, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic run_block(input bit dec, input int dip, input int dr, input int dfp);
    int rounds, done_cyc, exp_done;
    d_ip = dip; d_r = dr; d_fp = dfp;
    wait_ready();
    start = 1'b1; decrypt = dec;
    exp_done = (dip + 1) + 16 * (dr + 1) + (dfp + 1);
    rounds = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      decrypt = 1'($urandom_range(0, 1));
      if (cyc <= dip + 1) chk("ip_select_hold", ip_select, 1);
      if (round_go === 1'b1) begin
        rounds++;
        chk("round_go_cycle", cyc, (dip + 1) + (rounds - 1) * (dr + 1) + 1);
        chk("round_num", round_num, rounds);
        chk("key_amt", key_shift_amt, ref_amt(dec, rounds));
        chk("key_right", key_shift_right, dec);
      end
      chk("error_quiet", error, 0);
      if (done === 1'b1) begin
        done_cyc = cyc;
        chk("fp_select_at_done", fp_select, 1);
      end
    end
    chk("round_count", rounds, 16);
    chk("done_cycle", done_cyc, exp_done);
    @(negedge clk);
    check_idle("after_done");
  endtask

  initial begin
    int go5, err_cyc;
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Encrypt and decrypt with single-cycle stages.
    run_block(1'b0, 1, 1, 1);
    run_block(1'b1, 1, 1, 1);

    // Abort in IDLE is ignored; start wins over abort; abort in IP returns to IDLE.
    abort = 1'b1;
    @(negedge clk);
    check_idle("abort_idle");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_wins_busy", busy, 1);
    chk("start_wins_ipsel", ip_select, 1);
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_ip");

    // Round unit stalls in round 5.
    hang_round = 5; d_ip = 1; d_r = 1; d_fp = 1;
    wait_ready();
    start = 1'b1; decrypt = 1'b0;
    go5 = 0; err_cyc = 0;
    for (int cyc = 1; cyc <= 100 && err_cyc == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      chk("timeout_no_done", done, 0);
      if (round_go === 1'b1 && round_num === 5'd5) go5 = cyc;
      if (error === 1'b1) err_cyc = cyc;
    end
    chk("round5_go_cycle", go5, 11);
    chk("timeout_error_cycle", err_cyc, go5 + 16);
    @(negedge clk);
    check_idle("after_timeout");
    hang_round = 0;

    // Abort while waiting in round 9.
    d_ip = 1; d_r = 3; d_fp = 1;
    wait_ready();
    start = 1'b1; decrypt = 1'b1;
    go5 = 0;
    for (int cyc = 1; cyc <= 200 && go5 == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (round_go === 1'b1 && round_num === 5'd9) go5 = cyc;
    end
    chk("round9_go_cycle", go5, 2 + 8 * 4 + 1);
    @(negedge clk);
    chk("abort_in_rwait_nogo", round_go, 0);
    chk("abort_in_rwait_busy", busy, 1);
    abort = 1'b1;
    chk("abort_cycle_error", error, 0);
    chk("abort_cycle_done", done, 0);
    @(negedge clk);
    abort = 1'b0;
    check_idle("after_abort");
    run_block(1'b0, 1, 1, 1);

    // Stretched responders.
    run_block(1'b0, 3, 2, 1);

    // Randomized stage latencies and direction.
    for (int i = 0; i < 4; i++)
      run_block(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)),
                int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));

    // Asynchronous reset during FP.
    d_ip = 1; d_r = 1; d_fp = 3;
    wait_ready();
    start = 1'b1; decrypt = 1'b1;
    go5 = 0;
    for (int cyc = 1; cyc <= 200 && go5 == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (fp_select === 1'b1) go5 = cyc;
    end
    chk("fp_entry_cycle", go5, 35);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset_release");
    run_block(1'b0, 1, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
